alu_seq: RTL and testbench

Sequential, parametrised successor to the CPU's combinational ALU. Accepts one operation per start/ready handshake, computes INC, NAND, XOR, ADD, SUB and three shifts, and returns a registered result with N/Z/C/V flags and a one-cycle done pulse. Shifts run iteratively at SHIFT_STEP bits per cycle, trading latency for area. It sits between the register-file read stage and write-back of the CPU datapath.

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops and iterative shifts,
// one operation per start/ready handshake, registered result with N/Z/C/V.
module alu_seq #(
  parameter int DATA_W     = 14,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [2:0]        func,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [CNT_W-1:0]  STEP    = CNT_W'(SHIFT_STEP);
  localparam logic [DATA_W-1:0] AMT_MAX = DATA_W'(DATA_W);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_flags;
  logic              r_done;

  logic [DATA_W-1:0] w_bx;
  logic              w_cin;
  logic              w_arith;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;
  logic              w_is_shift;
  logic [CNT_W-1:0]  w_amt;
  logic [DATA_W:0]   w_step;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Shift amounts of DATA_W or more saturate: the result is fully filled.
  function automatic logic [CNT_W-1:0] f_sat_amt(input logic [DATA_W-1:0] b);
    if (b >= AMT_MAX) return AMT_MAX[CNT_W-1:0];
    else              return b[CNT_W-1:0];
  endfunction

  // Up to SHIFT_STEP single-bit shifts, stopping at the remaining count.
  // Returns {last bit shifted out, shifted value}.
  function automatic logic [DATA_W:0] f_shift_step(input logic [DATA_W-1:0] sh,
                                                   input logic [CNT_W-1:0]  rem,
                                                   input logic [2:0]        op);
    logic [DATA_W-1:0] s;
    logic              c;
    s = sh;
    c = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (CNT_W'(i) < rem) begin
        case (op)
          3'b111:  begin c = s[DATA_W-1]; s = {s[DATA_W-2:0], 1'b0}; end
          3'b110:  begin c = s[0];        s = {1'b0, s[DATA_W-1:1]}; end
          default: begin c = s[0];        s = {s[DATA_W-1], s[DATA_W-1:1]}; end
        endcase
      end
    end
    return {c, s};
  endfunction

  function automatic logic [3:0] f_flags(input logic [DATA_W-1:0] r,
                                         input logic c,
                                         input logic v);
    return {r[DATA_W-1], (r == '0), c, v};
  endfunction

  // INC, ADD and SUB all share one adder: A + B' + cin.
  always_comb begin
    w_bx    = '0;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    case (func)
      3'b000:  begin w_cin = 1'b1; w_arith = 1'b1; end
      3'b100:  begin w_bx = data1; w_arith = 1'b1; end
      3'b101:  begin w_bx = ~data1; w_cin = 1'b1; w_arith = 1'b1; end
      default: ;
    endcase
    w_sum = {1'b0, data0} + {1'b0, w_bx} + {{DATA_W{1'b0}}, w_cin};
    case (func)
      3'b001:                 w_res = ~(data0 & data1);
      3'b010:                 w_res = data0 ^ data1;
      3'b011, 3'b110, 3'b111: w_res = data0;
      default:                w_res = w_sum[DATA_W-1:0];
    endcase
    w_c = w_arith & w_sum[DATA_W];
    w_v = w_arith & (data0[DATA_W-1] == w_bx[DATA_W-1]) &
          (w_sum[DATA_W-1] != data0[DATA_W-1]);
  end

  assign w_is_shift = (func == 3'b011) || (func[2:1] == 2'b11);
  assign w_amt      = f_sat_amt(data1);
  assign w_step     = f_shift_step(r_sh, r_cnt, r_op);
  assign w_cnt_nxt  = (r_cnt > STEP) ? (r_cnt - STEP) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_is_shift || (w_amt == '0)) begin
              r_result <= w_res;
              r_flags  <= f_flags(w_res, w_c, w_v);
              r_done   <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_cnt   <= w_amt;
            end
          end
        end
        default: begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == '0) begin
            r_result <= w_step[DATA_W-1:0];
            r_flags  <= f_flags(w_step[DATA_W-1:0], w_step[DATA_W], 1'b0);
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Operand/shift datapath registers carry no reset; only control does.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      if (start) begin
        r_op <= func;
        r_sh <= data0;
      end
    end else begin
      r_sh <= w_step[DATA_W-1:0];
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table run on SHIFT_STEP=1 and 2
// instances, plus back-to-back, busy-start and mid-shift reset sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [2:0]  func;
  logic [13:0] data0, data1;
  logic        ready1, ready2, done1, done2;
  logic [13:0] result1, result2;
  logic [3:0]  flags1, flags2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_W(14), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready1), .func(func),
    .data0(data0), .data1(data1), .result(result1), .flags(flags1), .done(done1)
  );

  alu_seq #(.DATA_W(14), .SHIFT_STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .ready(ready2), .func(func),
    .data0(data0), .data1(data1), .result(result2), .flags(flags2), .done(done2)
  );

  typedef struct {
    logic [2:0]  f;
    logic [13:0] a;
    logic [13:0] b;
    logic [13:0] r;
    logic [3:0]  fl;
    int          s1;
    int          s2;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat1, lat2, n1, n2, low1;
    @(negedge clk);
    func = v.f; data0 = v.a; data1 = v.b;
    start1 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    lat1 = -1; lat2 = -1; n1 = 0; n2 = 0; low1 = 0;
    for (int c = 0; c < 40; c++) begin
      if (done1) begin n1++; if (lat1 < 0) lat1 = c; end
      if (done2) begin n2++; if (lat2 < 0) lat2 = c; end
      if (!ready1 && lat1 < 0) low1++;
      if (lat1 >= 0 && lat2 >= 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (done1) n1++;
    if (done2) n2++;
    chk($sformatf("v%0d_result_s1", idx), 32'(result1), 32'(v.r));
    chk($sformatf("v%0d_flags_s1", idx), 32'(flags1), 32'(v.fl));
    chk($sformatf("v%0d_latency_s1", idx), lat1, v.s1);
    chk($sformatf("v%0d_readylow_s1", idx), low1, v.s1);
    chk($sformatf("v%0d_pulses_s1", idx), n1, 1);
    chk($sformatf("v%0d_result_s2", idx), 32'(result2), 32'(v.r));
    chk($sformatf("v%0d_flags_s2", idx), 32'(flags2), 32'(v.fl));
    chk($sformatf("v%0d_latency_s2", idx), lat2, v.s2);
    chk($sformatf("v%0d_pulses_s2", idx), n2, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    //            func    A        B        result   NZCV     s1  s2
    tv[0]  = '{3'b000, 14'h3FFF, 14'h0000, 14'h0000, 4'b0110, 0,  0};
    tv[1]  = '{3'b100, 14'h1FFF, 14'h0001, 14'h2000, 4'b1001, 0,  0};
    tv[2]  = '{3'b101, 14'h0005, 14'h0005, 14'h0000, 4'b0110, 0,  0};
    tv[3]  = '{3'b001, 14'h3FFF, 14'h3FFF, 14'h0000, 4'b0100, 0,  0};
    tv[4]  = '{3'b001, 14'h0F0F, 14'h00FF, 14'h3FF0, 4'b1000, 0,  0};
    tv[5]  = '{3'b010, 14'h2AAA, 14'h3FFF, 14'h1555, 4'b0000, 0,  0};
    tv[6]  = '{3'b100, 14'h3FFF, 14'h0001, 14'h0000, 4'b0110, 0,  0};
    tv[7]  = '{3'b101, 14'h0000, 14'h0001, 14'h3FFF, 4'b1000, 0,  0};
    tv[8]  = '{3'b101, 14'h2000, 14'h0001, 14'h1FFF, 4'b0011, 0,  0};
    tv[9]  = '{3'b011, 14'h2000, 14'h0003, 14'h3C00, 4'b1000, 3,  2};
    tv[10] = '{3'b011, 14'h2000, 14'h0014, 14'h3FFF, 4'b1010, 14, 7};
    tv[11] = '{3'b111, 14'h0001, 14'h000D, 14'h2000, 4'b1000, 13, 7};
    tv[12] = '{3'b110, 14'h3FFF, 14'h0000, 14'h3FFF, 4'b1000, 0,  0};
    tv[13] = '{3'b110, 14'h3FFF, 14'h0001, 14'h1FFF, 4'b0010, 1,  1};
    tv[14] = '{3'b111, 14'h0003, 14'h000E, 14'h0000, 4'b0110, 14, 7};
    tv[15] = '{3'b110, 14'h2000, 14'h3FFF, 14'h0000, 4'b0110, 14, 7};
    tv[16] = '{3'b000, 14'h1FFF, 14'h0000, 14'h2000, 4'b1001, 0,  0};
    tv[17] = '{3'b011, 14'h1000, 14'h0002, 14'h0400, 4'b0000, 2,  1};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    func = 3'b000; data0 = '0; data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready1), 32'd1);
    chk("reset_done", 32'(done1), 32'd0);
    chk("reset_result", 32'(result1), 32'd0);
    chk("reset_flags", 32'(flags1), 32'd0);
    chk("reset_ready_s2", 32'(ready2), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(i, tv[i]);

    // ADD, then SUB issued on the ADD's done cycle
    @(negedge clk);
    func = 3'b100; data0 = 14'h1FFF; data1 = 14'h0001; start1 = 1'b1;
    @(posedge clk); #1;
    chk("b2b_add_done", 32'(done1), 32'd1);
    chk("b2b_add_ready", 32'(ready1), 32'd1);
    chk("b2b_add_result", 32'(result1), 32'h2000);
    chk("b2b_add_flags", 32'(flags1), 32'b1001);
    func = 3'b101; data0 = 14'h0005; data1 = 14'h0005;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("b2b_sub_done", 32'(done1), 32'd1);
    chk("b2b_sub_result", 32'(result1), 32'h0000);
    chk("b2b_sub_flags", 32'(flags1), 32'b0110);
    @(posedge clk); #1;
    chk("b2b_done_drop", 32'(done1), 32'd0);

    // start held with new operands while an SRA is shifting
    @(negedge clk);
    func = 3'b011; data0 = 14'h2000; data1 = 14'h0003; start1 = 1'b1;
    @(posedge clk); #1;
    func = 3'b010; data0 = 14'h1234; data1 = 14'h0F0F;
    chk("busy_ready_low", 32'(ready1), 32'd0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done1) begin pulses++; start1 = 1'b0; break; end
      @(posedge clk); #1;
    end
    chk("busy_result", 32'(result1), 32'h3C00);
    chk("busy_flags", 32'(flags1), 32'b1000);
    start1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done1) pulses++;
    end
    chk("busy_pulses", pulses, 1);
    chk("busy_result_held", 32'(result1), 32'h3C00);

    // reset on the 2nd SHIFT cycle of a 10-bit SRL
    @(negedge clk);
    func = 3'b110; data0 = 14'h3FFF; data1 = 14'd10; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(ready1), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(ready1), 32'd1);
    chk("abort_result", 32'(result1), 32'd0);
    chk("abort_flags", 32'(flags1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done1) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_result_held", 32'(result1), 32'd0);
    @(negedge clk);
    func = 3'b010; data0 = 14'h2AAA; data1 = 14'h3FFF; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("post_xor_done", 32'(done1), 32'd1);
    chk("post_xor_result", 32'(result1), 32'h1555);
    chk("post_xor_flags", 32'(flags1), 32'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
